accel_wb_dispatch: RTL and testbench

//  Consumer end of the MEM/WB accelerator control fields: turns latched writeback-stage

---
 rtl/accel_wb_dispatch_pkg.sv | 45 ++++
 rtl/accel_wb_dispatch_if.sv | 67 ++++++
 rtl/accel_wb_dispatch_size_fmt.sv | 30 +++
 rtl/accel_wb_dispatch.sv | 192 +++++++++++++++++++
 tb/tb_accel_wb_dispatch.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/accel_wb_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_wb_dispatch_pkg
// Purpose  : Shared encodings for the writeback-stage accelerator dispatcher:
//            busy-unit IDs, access-size codes, FSM states and start arbitration.
// Revision : 1.0  initial release
// ============================================================================
package accel_wb_dispatch_pkg;

  // Identity of the unit owning the single in-flight job
  localparam logic [1:0] BUSY_NONE   = 2'd0;
  localparam logic [1:0] BUSY_NTT    = 2'd1;
  localparam logic [1:0] BUSY_PWAM   = 2'd2;
  localparam logic [1:0] BUSY_KECCAK = 2'd3;

  // Access size codes carried on wb_size; any code >= SZ_DWORD is a dword
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Fixed-priority start arbitration: NTT beats PWAM beats Keccak
  function automatic logic [1:0] start_grant(input logic ntt, input logic pwam,
                                             input logic keccak);
    logic [1:0] g;
    g = BUSY_NONE;
    if (ntt)         g = BUSY_NTT;
    else if (pwam)   g = BUSY_PWAM;
    else if (keccak) g = BUSY_KECCAK;
    return g;
  endfunction

  // True when more than one start strobe arrives together
  function automatic logic multi_start(input logic ntt, input logic pwam,
                                       input logic keccak);
    return (ntt & pwam) | (ntt & keccak) | (pwam & keccak);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_wb_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : accel_wb_dispatch_if
// Purpose  : Bundles the MEM/WB control fields, the accelerator-side bus and
//            the dispatcher status outputs. master = pipeline/accelerator
//            side, slave = dispatcher.
// Revision : 1.0  initial release
// ============================================================================
interface accel_wb_dispatch_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 10
);
  // MEM/WB control strobes and payload
  logic                 wb_ntt_we;
  logic                 wb_ntt_start;
  logic                 wb_pwam_wea;
  logic                 wb_pwam_web;
  logic                 wb_pwam_start;
  logic                 wb_keccak_we;
  logic                 wb_keccak_start;
  logic [2:0]           wb_size;
  logic [DATA_BITS-1:0] wb_addr;
  logic [DATA_BITS-1:0] wb_data;

  // Registered accelerator bus
  logic                 ntt_we;
  logic                 pwam_wea;
  logic                 pwam_web;
  logic                 keccak_we;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [DATA_BITS-1:0] acc_din;
  logic                 ntt_start;
  logic                 pwam_start;
  logic                 keccak_start;

  // Accelerator completion inputs
  logic                 ntt_done;
  logic                 pwam_done;
  logic                 keccak_done;

  // Status
  logic                 stall;
  logic [1:0]           busy_id;
  logic [7:0]           job_cnt;
  logic                 timeout_err;
  logic                 multi_err;

  modport master (
    output wb_ntt_we, wb_ntt_start, wb_pwam_wea, wb_pwam_web, wb_pwam_start,
           wb_keccak_we, wb_keccak_start, wb_size, wb_addr, wb_data,
           ntt_done, pwam_done, keccak_done,
    input  ntt_we, pwam_wea, pwam_web, keccak_we, acc_addr, acc_din,
           ntt_start, pwam_start, keccak_start,
           stall, busy_id, job_cnt, timeout_err, multi_err
  );

  modport slave (
    input  wb_ntt_we, wb_ntt_start, wb_pwam_wea, wb_pwam_web, wb_pwam_start,
           wb_keccak_we, wb_keccak_start, wb_size, wb_addr, wb_data,
           ntt_done, pwam_done, keccak_done,
    output ntt_we, pwam_wea, pwam_web, keccak_we, acc_addr, acc_din,
           ntt_start, pwam_start, keccak_start,
           stall, busy_id, job_cnt, timeout_err, multi_err
  );

endinterface
`default_nettype wire

// File: rtl/accel_wb_dispatch_size_fmt.sv
`default_nettype none
// ============================================================================
// Module   : accel_size_fmt
// Purpose  : Keeps the low byte/half/word/dword of the writeback data as
//            selected by the access size and zero-extends it.
// Revision : 1.0  initial release
// ============================================================================
module accel_size_fmt
  import accel_wb_dispatch_pkg::*;
#(
  parameter int DATA_BITS = 64
) (
  input  wire logic [2:0]           wb_size_i,
  input  wire logic [DATA_BITS-1:0] wb_data_i,
  output logic      [DATA_BITS-1:0] acc_din_o
);

  // Select the active lanes; unused upper lanes are forced to zero
  always_comb begin
    acc_din_o = '0;
    case (wb_size_i)
      SZ_BYTE: acc_din_o[7:0]  = wb_data_i[7:0];
      SZ_HALF: acc_din_o[15:0] = wb_data_i[15:0];
      SZ_WORD: acc_din_o[31:0] = wb_data_i[31:0];
      default: acc_din_o       = wb_data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/accel_wb_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : accel_wb_dispatch
// Purpose  : Converts MEM/WB accelerator strobes into registered accelerator
//            bus transactions, tracks the single in-flight job, stalls the
//            pipeline while a job runs and flags timeouts / start collisions.
// Revision : 1.0  initial release
// ============================================================================
module accel_wb_dispatch
  import accel_wb_dispatch_pkg::*;
#(
  parameter int DATA_BITS   = 64,
  parameter int ADDR_BITS   = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  wire logic         clk,
  input  wire logic         rst,
  accel_wb_dispatch_if.slave bus
);

  // Timeout counter only needs to reach TIMEOUT_CYC-1
  localparam int                CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit                TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [1:0]           busy_q, busy_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;
  logic [7:0]           job_q, job_d;
  logic                 terr_q, terr_d;
  logic                 merr_q, merr_d;
  logic                 ntt_we_q, ntt_we_d;
  logic                 pwam_wea_q, pwam_wea_d;
  logic                 pwam_web_q, pwam_web_d;
  logic                 keccak_we_q, keccak_we_d;
  logic                 ntt_start_q, ntt_start_d;
  logic                 pwam_start_q, pwam_start_d;
  logic                 keccak_start_q, keccak_start_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] din_q, din_d;

  logic [DATA_BITS-1:0] w_fmt;
  logic                 w_cmd_present;
  logic                 w_any_we;
  logic [1:0]           w_grant;
  logic                 w_multi;
  logic                 w_active_done;

  // Byte address bits below the doubleword and above the local window are not used
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.wb_addr[DATA_BITS-1:ADDR_BITS+3], bus.wb_addr[2:0]};

  accel_size_fmt #(
    .DATA_BITS (DATA_BITS)
  ) u_size_fmt (
    .wb_size_i (bus.wb_size),
    .wb_data_i (bus.wb_data),
    .acc_din_o (w_fmt)
  );

  // Decode incoming strobes, start arbitration and the running unit's done
  always_comb begin
    w_any_we      = bus.wb_ntt_we | bus.wb_pwam_wea | bus.wb_pwam_web | bus.wb_keccak_we;
    w_cmd_present = w_any_we | bus.wb_ntt_start | bus.wb_pwam_start | bus.wb_keccak_start;
    w_grant       = start_grant(bus.wb_ntt_start, bus.wb_pwam_start, bus.wb_keccak_start);
    w_multi       = multi_start(bus.wb_ntt_start, bus.wb_pwam_start, bus.wb_keccak_start);
    w_active_done = 1'b0;
    case (busy_q)
      BUSY_NTT:    w_active_done = bus.ntt_done;
      BUSY_PWAM:   w_active_done = bus.pwam_done;
      BUSY_KECCAK: w_active_done = bus.keccak_done;
      default:     w_active_done = 1'b0;
    endcase
  end

  // Next-state logic: accept commands in IDLE, watch done/timeout in RUN
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    tcnt_d         = tcnt_q;
    job_d          = job_q;
    terr_d         = terr_q;
    merr_d         = merr_q;
    addr_d         = addr_q;
    din_d          = din_q;
    ntt_we_d       = 1'b0;
    pwam_wea_d     = 1'b0;
    pwam_web_d     = 1'b0;
    keccak_we_d    = 1'b0;
    ntt_start_d    = 1'b0;
    pwam_start_d   = 1'b0;
    keccak_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ntt_we_d    = bus.wb_ntt_we;
        pwam_wea_d  = bus.wb_pwam_wea;
        pwam_web_d  = bus.wb_pwam_web;
        keccak_we_d = bus.wb_keccak_we;
        // Address and data are shared by all write strobes of the same cycle
        if (w_any_we) begin
          addr_d = bus.wb_addr[ADDR_BITS+2:3];
          din_d  = w_fmt;
        end
        if (w_grant != BUSY_NONE) begin
          state_d        = ST_RUN;
          busy_d         = w_grant;
          tcnt_d         = '0;
          ntt_start_d    = (w_grant == BUSY_NTT);
          pwam_start_d   = (w_grant == BUSY_PWAM);
          keccak_start_d = (w_grant == BUSY_KECCAK);
        end
        if (w_multi) begin
          merr_d = 1'b1;
        end
      end
      ST_RUN: begin
        // A completion in the same cycle as the timeout still counts as a job
        if (w_active_done) begin
          state_d = ST_IDLE;
          busy_d  = BUSY_NONE;
          job_d   = job_q + 8'd1;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          state_d = ST_IDLE;
          busy_d  = BUSY_NONE;
          terr_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = BUSY_NONE;
      end
    endcase
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      busy_q         <= BUSY_NONE;
      tcnt_q         <= '0;
      job_q          <= '0;
      terr_q         <= 1'b0;
      merr_q         <= 1'b0;
      addr_q         <= '0;
      din_q          <= '0;
      ntt_we_q       <= 1'b0;
      pwam_wea_q     <= 1'b0;
      pwam_web_q     <= 1'b0;
      keccak_we_q    <= 1'b0;
      ntt_start_q    <= 1'b0;
      pwam_start_q   <= 1'b0;
      keccak_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      tcnt_q         <= tcnt_d;
      job_q          <= job_d;
      terr_q         <= terr_d;
      merr_q         <= merr_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      ntt_we_q       <= ntt_we_d;
      pwam_wea_q     <= pwam_wea_d;
      pwam_web_q     <= pwam_web_d;
      keccak_we_q    <= keccak_we_d;
      ntt_start_q    <= ntt_start_d;
      pwam_start_q   <= pwam_start_d;
      keccak_start_q <= keccak_start_d;
    end
  end

  // Stall is the only combinational output: hold any command arriving mid-job
  assign bus.stall        = (state_q == ST_RUN) & w_cmd_present;
  assign bus.busy_id      = busy_q;
  assign bus.job_cnt      = job_q;
  assign bus.timeout_err  = terr_q;
  assign bus.multi_err    = merr_q;
  assign bus.acc_addr     = addr_q;
  assign bus.acc_din      = din_q;
  assign bus.ntt_we       = ntt_we_q;
  assign bus.pwam_wea     = pwam_wea_q;
  assign bus.pwam_web     = pwam_web_q;
  assign bus.keccak_we    = keccak_we_q;
  assign bus.ntt_start    = ntt_start_q;
  assign bus.pwam_start   = pwam_start_q;
  assign bus.keccak_start = keccak_start_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_wb_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_wb_dispatch
// Purpose  : Directed self-checking bench for accel_wb_dispatch.
// Revision : 1.0  initial release
// ============================================================================
module tb_accel_wb_dispatch;
  import accel_wb_dispatch_pkg::*;

  localparam int DATA_BITS   = 64;
  localparam int ADDR_BITS   = 10;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  accel_wb_dispatch_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  accel_wb_dispatch #(
    .DATA_BITS   (DATA_BITS),
    .ADDR_BITS   (ADDR_BITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wb_ntt_we = 0; bus.wb_ntt_start = 0; bus.wb_pwam_wea = 0; bus.wb_pwam_web = 0;
    bus.wb_pwam_start = 0; bus.wb_keccak_we = 0; bus.wb_keccak_start = 0;
    bus.wb_size = 3'd0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ntt_done = 0; bus.pwam_done = 0; bus.keccak_done = 0;
  endtask

  task automatic test_reset();
    logic [95:0] outs;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    outs = {bus.ntt_we, bus.pwam_wea, bus.pwam_web, bus.keccak_we, bus.acc_addr, bus.acc_din,
            bus.ntt_start, bus.pwam_start, bus.keccak_start, bus.stall, bus.busy_id,
            bus.job_cnt, bus.timeout_err, bus.multi_err};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.wb_ntt_we = 1; bus.wb_size = 3'd3; bus.wb_addr = 64'h40;
    bus.wb_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    n_cmp++; if (bus.ntt_we !== 1'b1) begin n_bad++; $display("FAIL wr_ntt_we: got %b want 1", bus.ntt_we); end
    n_cmp++; if (bus.acc_addr !== 10'd8) begin n_bad++; $display("FAIL wr_addr: got %h want 008", bus.acc_addr); end
    n_cmp++; if (bus.acc_din !== 64'hDEADBEEF_CAFEF00D) begin n_bad++; $display("FAIL wr_din_dword: got %h want deadbeefcafef00d", bus.acc_din); end
    n_cmp++; if ({bus.pwam_wea, bus.pwam_web, bus.keccak_we} !== 3'b000) begin n_bad++; $display("FAIL wr_other_we: got %b want 000", {bus.pwam_wea, bus.pwam_web, bus.keccak_we}); end
    bus.wb_size = 3'd0;
    tick();
    n_cmp++; if (bus.acc_din !== 64'h0D) begin n_bad++; $display("FAIL wr_din_byte: got %h want d", bus.acc_din); end
    clear_inputs();
    tick();
    n_cmp++; if (bus.ntt_we !== 1'b0) begin n_bad++; $display("FAIL wr_we_one_cycle: got %b want 0", bus.ntt_we); end
  endtask

  task automatic test_size_multi_write();
    bus.wb_pwam_wea = 1; bus.wb_pwam_web = 1; bus.wb_size = 3'd1;
    bus.wb_addr = 64'h1FF8; bus.wb_data = 64'h11223344_55667788;
    tick();
    n_cmp++; if ({bus.ntt_we, bus.pwam_wea, bus.pwam_web, bus.keccak_we} !== 4'b0110) begin n_bad++; $display("FAIL mw_strobes: got %b want 0110", {bus.ntt_we, bus.pwam_wea, bus.pwam_web, bus.keccak_we}); end
    n_cmp++; if (bus.acc_din !== 64'h7788) begin n_bad++; $display("FAIL mw_din_half: got %h want 7788", bus.acc_din); end
    n_cmp++; if (bus.acc_addr !== 10'h3FF) begin n_bad++; $display("FAIL mw_addr_top: got %h want 3ff", bus.acc_addr); end
    bus.wb_size = 3'd2;
    tick();
    n_cmp++; if (bus.acc_din !== 64'h55667788) begin n_bad++; $display("FAIL mw_din_word: got %h want 55667788", bus.acc_din); end
    bus.wb_size = 3'd7; bus.wb_addr = 64'h2008;
    tick();
    n_cmp++; if (bus.acc_din !== 64'h11223344_55667788) begin n_bad++; $display("FAIL mw_din_size7: got %h want 1122334455667788", bus.acc_din); end
    n_cmp++; if (bus.acc_addr !== 10'h001) begin n_bad++; $display("FAIL mw_addr_wrap: got %h want 001", bus.acc_addr); end
    clear_inputs();
    tick();
  endtask

  task automatic test_run_hazard();
    bus.wb_pwam_start = 1;
    tick();
    n_cmp++; if ({bus.ntt_start, bus.pwam_start, bus.keccak_start} !== 3'b010) begin n_bad++; $display("FAIL hz_start: got %b want 010", {bus.ntt_start, bus.pwam_start, bus.keccak_start}); end
    n_cmp++; if (bus.busy_id !== BUSY_PWAM) begin n_bad++; $display("FAIL hz_busy: got %0d want 2", bus.busy_id); end
    bus.wb_pwam_start = 0; bus.wb_keccak_we = 1; bus.wb_addr = 64'h18; bus.wb_data = 64'h55; bus.wb_size = 3'd3;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL hz_stall: got %b want 1", bus.stall); end
    tick();
    n_cmp++; if ({bus.pwam_start, bus.keccak_we} !== 2'b00) begin n_bad++; $display("FAIL hz_held: got %b want 00", {bus.pwam_start, bus.keccak_we}); end
    bus.pwam_done = 1;
    tick();
    n_cmp++; if ({bus.busy_id, bus.job_cnt, bus.stall, bus.keccak_we} !== {BUSY_NONE, 8'd1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL hz_done: got busy=%0d jobs=%0d stall=%b we=%b want 0 1 0 0", bus.busy_id, bus.job_cnt, bus.stall, bus.keccak_we); end
    bus.pwam_done = 0;
    tick();
    n_cmp++; if ({bus.keccak_we, bus.acc_addr, bus.acc_din} !== {1'b1, 10'd3, 64'h55}) begin n_bad++; $display("FAIL hz_release: got we=%b addr=%h din=%h want 1 003 55", bus.keccak_we, bus.acc_addr, bus.acc_din); end
    clear_inputs();
    tick();
  endtask

  task automatic test_multi_start();
    bus.wb_ntt_start = 1; bus.wb_keccak_start = 1;
    tick();
    n_cmp++; if ({bus.ntt_start, bus.pwam_start, bus.keccak_start} !== 3'b100) begin n_bad++; $display("FAIL ms_start: got %b want 100", {bus.ntt_start, bus.pwam_start, bus.keccak_start}); end
    n_cmp++; if ({bus.busy_id, bus.multi_err} !== {BUSY_NTT, 1'b1}) begin n_bad++; $display("FAIL ms_busy_err: got busy=%0d err=%b want 1 1", bus.busy_id, bus.multi_err); end
    clear_inputs();
    bus.pwam_done = 1;
    tick();
    n_cmp++; if ({bus.busy_id, bus.job_cnt, bus.ntt_start} !== {BUSY_NTT, 8'd1, 1'b0}) begin n_bad++; $display("FAIL ms_foreign_done: got busy=%0d jobs=%0d start=%b want 1 1 0", bus.busy_id, bus.job_cnt, bus.ntt_start); end
    bus.pwam_done = 0; bus.ntt_done = 1;
    tick();
    n_cmp++; if ({bus.busy_id, bus.job_cnt} !== {BUSY_NONE, 8'd2}) begin n_bad++; $display("FAIL ms_done: got busy=%0d jobs=%0d want 0 2", bus.busy_id, bus.job_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bus.wb_keccak_start = 1;
    tick();
    n_cmp++; if ({bus.keccak_start, bus.busy_id} !== {1'b1, BUSY_KECCAK}) begin n_bad++; $display("FAIL to_start: got start=%b busy=%0d want 1 3", bus.keccak_start, bus.busy_id); end
    clear_inputs();
    repeat (15) tick();
    n_cmp++; if ({bus.busy_id, bus.timeout_err, bus.keccak_start} !== {BUSY_KECCAK, 1'b0, 1'b0}) begin n_bad++; $display("FAIL to_before: got busy=%0d err=%b start=%b want 3 0 0", bus.busy_id, bus.timeout_err, bus.keccak_start); end
    tick();
    n_cmp++; if ({bus.busy_id, bus.timeout_err, bus.job_cnt} !== {BUSY_NONE, 1'b1, 8'd2}) begin n_bad++; $display("FAIL to_fire: got busy=%0d err=%b jobs=%0d want 0 1 2", bus.busy_id, bus.timeout_err, bus.job_cnt); end
    tick();
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", bus.timeout_err); end
  endtask

  task automatic test_rst_mid_run();
    logic [95:0] outs;
    bus.wb_ntt_start = 1;
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    outs = {bus.ntt_we, bus.pwam_wea, bus.pwam_web, bus.keccak_we, bus.acc_addr, bus.acc_din,
            bus.ntt_start, bus.pwam_start, bus.keccak_start, bus.stall, bus.busy_id,
            bus.job_cnt, bus.timeout_err, bus.multi_err};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_async: got %h want 0", outs); end
    #2;
    rst = 1'b0;
    bus.ntt_done = 1;
    tick(); tick();
    n_cmp++; if ({bus.busy_id, bus.job_cnt} !== {BUSY_NONE, 8'd0}) begin n_bad++; $display("FAIL rst_done_ignored: got busy=%0d jobs=%0d want 0 0", bus.busy_id, bus.job_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_job_wrap();
    int exp_jobs;
    exp_jobs = 0;
    for (int i = 0; i < 256; i++) begin
      bus.wb_pwam_start = 1;
      tick();
      bus.wb_pwam_start = 0; bus.pwam_done = 1;
      tick();
      bus.pwam_done = 0;
      exp_jobs = (exp_jobs + 1) % 256;
      if (i == 254) begin
        n_cmp++; if (bus.job_cnt !== 8'(exp_jobs)) begin n_bad++; $display("FAIL wrap_255: got %0d want %0d", bus.job_cnt, exp_jobs); end
      end
    end
    n_cmp++; if (bus.job_cnt !== 8'(exp_jobs)) begin n_bad++; $display("FAIL wrap_zero: got %0d want %0d", bus.job_cnt, exp_jobs); end
    tick();
  endtask

  task automatic test_done_timeout_tie();
    bus.wb_ntt_start = 1;
    tick();
    clear_inputs();
    repeat (15) tick();
    bus.ntt_done = 1;
    tick();
    n_cmp++; if ({bus.busy_id, bus.job_cnt, bus.timeout_err} !== {BUSY_NONE, 8'd1, 1'b0}) begin n_bad++; $display("FAIL tie_done_wins: got busy=%0d jobs=%0d err=%b want 0 1 0", bus.busy_id, bus.job_cnt, bus.timeout_err); end
    tick();
    n_cmp++; if (bus.job_cnt !== 8'd1) begin n_bad++; $display("FAIL tie_idle_done_ignored: got %0d want 1", bus.job_cnt); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_size_multi_write();
    test_run_hazard();
    test_multi_start();
    test_timeout();
    test_rst_mid_run();
    test_job_wrap();
    test_done_timeout_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
